horner_ctrl_fsm: RTL and testbench

//  Parametrised sequencer for Horner-form ADC-correction polynomial evaluation.
//  - Accepts one centred/scaled ADC sample and issues ORDER+1 multiply-add requests to the multiply-adder.
//  - Steps the coefficient select from the order down to 0.
//  - Pulses x_output_ready when the corrected value is valid.
//  - Adds run-time order selection, input-drop reporting and an optional stall watchdog.

---
 rtl/horner_ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_horner_ctrl_fsm.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : horner_ctrl_fsm
// Purpose  : Horner-form polynomial sequencer issuing n+1 multiply-add steps.
// Option   : HORNER_FSM_WATCHDOG_EN enables the WAIT-state stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module horner_ctrl_fsm #(
  parameter int ORDER          = 10,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             adc_input_ready_i,
  input  logic [SEL_W-1:0] order_cfg_i,
  input  logic             multiplyadder_out_ready_i,
  output logic             multiplyadder_in_ready_o,
  output logic [SEL_W-1:0] coefficent_select_o,
  output logic             acc_clear_o,
  output logic             x_output_ready_o,
  output logic             busy_o,
  output logic             input_dropped_o,
  output logic             timeout_o
);

  localparam logic [SEL_W-1:0] c_ORDER_SEL = SEL_W'(ORDER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             in_ready_q, acc_clear_q, x_ready_q, busy_q, dropped_q, timeout_q;
  logic             w_accept;
  logic             w_abort;
  logic             w_busy;
  logic             w_wd_expire;
  logic [SEL_W-1:0] w_order_clamped;

  assign w_busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign w_order_clamped = (order_cfg_i > c_ORDER_SEL) ? c_ORDER_SEL : order_cfg_i;

`ifdef HORNER_FSM_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  assign w_wd_expire = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive WAIT cycles; any exit from WAIT restarts it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q <= '0;
    end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign w_wd_expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sel_d = c_ORDER_SEL;
        if (adc_input_ready_i) w_accept = 1'b1;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (multiplyadder_out_ready_i) begin
          if (sel_q != '0) begin
            sel_d   = sel_q - SEL_W'(1);
            state_d = S_ISSUE;
          end else begin
            sel_d   = c_ORDER_SEL;
            state_d = S_DONE;
          end
        end else if (w_wd_expire) begin
          w_abort = 1'b1;
          sel_d   = c_ORDER_SEL;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        sel_d   = c_ORDER_SEL;
        state_d = S_IDLE;
        if (adc_input_ready_i) w_accept = 1'b1;
      end
      default: begin
        sel_d   = c_ORDER_SEL;
        state_d = S_IDLE;
      end
    endcase
    if (w_accept) begin
      sel_d   = w_order_clamped;
      state_d = S_ISSUE;
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      sel_q       <= c_ORDER_SEL;
      in_ready_q  <= 1'b0;
      acc_clear_q <= 1'b0;
      x_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      in_ready_q  <= (state_d == S_ISSUE);
      acc_clear_q <= w_accept;
      x_ready_q   <= (state_d == S_DONE);
      busy_q      <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      dropped_q   <= adc_input_ready_i && w_busy;
      timeout_q   <= w_abort;
    end
  end

  assign multiplyadder_in_ready_o = in_ready_q;
  assign coefficent_select_o      = sel_q;
  assign acc_clear_o              = acc_clear_q;
  assign x_output_ready_o         = x_ready_q;
  assign busy_o                   = busy_q;
  assign input_dropped_o          = dropped_q;
  assign timeout_o                = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_horner_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_horner_ctrl_fsm
// Purpose  : Directed self-checking bench for horner_ctrl_fsm with an L-cycle
//            multiply-adder model. Revision : 1.0
// ============================================================================
module tb_horner_ctrl_fsm;

  localparam int ORDER = 10;
  localparam int SEL_W = 4;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             adc;
  logic [SEL_W-1:0] cfg;
  logic             ma_out;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             acc_clear;
  logic             x_ready;
  logic             busy;
  logic             dropped;
  logic             timeout;

  int   checks   = 0;
  int   failures = 0;

  // multiply-adder model: out_ready follows in_ready by lat_l cycles
  int         lat_l    = 1;
  logic       model_en = 1'b0;
  logic       spur     = 1'b0;
  logic [7:0] pipe;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[6:0], in_ready};
  end
  assign ma_out = (model_en & pipe[lat_l-1]) | spur;

  horner_ctrl_fsm #(.ORDER(ORDER), .SEL_W(SEL_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i                     (clk),
    .reset_i                   (reset),
    .adc_input_ready_i         (adc),
    .order_cfg_i               (cfg),
    .multiplyadder_out_ready_i (ma_out),
    .multiplyadder_in_ready_o  (in_ready),
    .coefficent_select_o       (sel),
    .acc_clear_o               (acc_clear),
    .x_output_ready_o          (x_ready),
    .busy_o                    (busy),
    .input_dropped_o           (dropped),
    .timeout_o                 (timeout)
  );

  logic [SEL_W-1:0] obs_sel[$];
  int               obs_clr_cnt;
  logic             obs_clr_first;
  int               obs_lat;
  int               obs_drop;

  // Samples at negedges starting with the current one as cycle `start`;
  // returns at the negedge where x_output_ready is seen (obs_lat=-1 on budget expiry).
  task automatic observe(input int start, input int budget);
    obs_sel.delete();
    obs_clr_cnt   = 0;
    obs_clr_first = 1'b0;
    obs_drop      = 0;
    obs_lat       = -1;
    for (int c = start; c < start + budget; c++) begin
      if (in_ready) begin
        if (acc_clear) begin
          obs_clr_cnt++;
          if (obs_sel.size() == 0) obs_clr_first = 1'b1;
        end
        obs_sel.push_back(sel);
      end
      if (dropped) obs_drop++;
      if (x_ready) begin
        obs_lat = c;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Presents one sample for a single edge; returns at the negedge of cycle 1.
  task automatic drive_accept(input logic [SEL_W-1:0] c);
    @(negedge clk);
    adc = 1'b1;
    cfg = c;
    @(negedge clk);
    adc = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, acc_clear, x_ready, busy, dropped, timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {in_ready, acc_clear, x_ready, busy, dropped, timeout});
    end
    checks++;
    if (sel !== 4'(ORDER)) begin
      failures++;
      $display("FAIL reset_select: got %0d expected %0d", sel, ORDER);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_order;
    int exp_lat;
    lat_l    = 1;
    model_en = 1'b1;
    exp_lat  = (ORDER + 1) * (lat_l + 1) + 1;
    drive_accept(4'd10);
    observe(1, 200);
    checks++;
    if (obs_sel.size() !== ORDER + 1) begin
      failures++;
      $display("FAIL full_req_count: got %0d expected %0d", obs_sel.size(), ORDER + 1);
    end
    for (int i = 0; i < obs_sel.size(); i++) begin
      checks++;
      if (obs_sel[i] !== 4'(ORDER - i)) begin
        failures++;
        $display("FAIL full_select[%0d]: got %0d expected %0d", i, obs_sel[i], ORDER - i);
      end
    end
    checks++;
    if (obs_clr_cnt !== 1 || obs_clr_first !== 1'b1) begin
      failures++;
      $display("FAIL full_acc_clear: got count=%0d first=%b expected count=1 first=1",
               obs_clr_cnt, obs_clr_first);
    end
    checks++;
    if (obs_lat !== exp_lat) begin
      failures++;
      $display("FAIL full_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    checks++;
    if (busy !== 1'b0 || sel !== 4'(ORDER)) begin
      failures++;
      $display("FAIL full_done_state: got busy=%b sel=%0d expected busy=0 sel=%0d",
               busy, sel, ORDER);
    end
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_done_pulse: got %b expected 0", x_ready);
    end
  endtask

  task automatic test_order_clamp;
    lat_l    = 2;
    model_en = 1'b1;
    drive_accept(4'd3);
    cfg = 4'd0;
    observe(1, 200);
    checks++;
    if (obs_sel.size() !== 4) begin
      failures++;
      $display("FAIL ord3_req_count: got %0d expected 4", obs_sel.size());
    end
    for (int i = 0; i < obs_sel.size(); i++) begin
      checks++;
      if (obs_sel[i] !== 4'(3 - i)) begin
        failures++;
        $display("FAIL ord3_select[%0d]: got %0d expected %0d", i, obs_sel[i], 3 - i);
      end
    end
    checks++;
    if (obs_lat !== 13) begin
      failures++;
      $display("FAIL ord3_latency: got %0d expected 13", obs_lat);
    end
    @(negedge clk);
    drive_accept(4'd15);
    observe(1, 200);
    checks++;
    if (obs_sel.size() !== ORDER + 1 || obs_sel[0] !== 4'(ORDER)) begin
      failures++;
      $display("FAIL clamp_requests: got count=%0d first=%0d expected count=%0d first=%0d",
               obs_sel.size(), obs_sel[0], ORDER + 1, ORDER);
    end
    checks++;
    if (obs_lat !== (ORDER + 1) * 3 + 1) begin
      failures++;
      $display("FAIL clamp_latency: got %0d expected %0d", obs_lat, (ORDER + 1) * 3 + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    lat_l    = 1;
    model_en = 1'b1;
    @(negedge clk);
    adc = 1'b1;
    cfg = 4'd2;
    @(negedge clk);
    observe(1, 100);
    checks++;
    if (obs_lat !== 7 || obs_sel.size() !== 3) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d reqs=%0d expected lat=7 reqs=3",
               obs_lat, obs_sel.size());
    end
    checks++;
    if (obs_drop !== 6) begin
      failures++;
      $display("FAIL b2b_dropped: got %0d expected 6", obs_drop);
    end
    @(negedge clk);
    checks++;
    if ({in_ready, acc_clear, busy} !== 3'b111 || sel !== 4'd2) begin
      failures++;
      $display("FAIL b2b_reaccept: got ir/clr/busy=%b sel=%0d expected 111 sel=2",
               {in_ready, acc_clear, busy}, sel);
    end
    adc = 1'b0;
    observe(1, 100);
    checks++;
    if (obs_lat !== 7 || obs_sel.size() !== 3 || obs_clr_cnt !== 1 || obs_drop !== 0) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d reqs=%0d clr=%0d drop=%0d expected 7 3 1 0",
               obs_lat, obs_sel.size(), obs_clr_cnt, obs_drop);
    end
    for (int i = 0; i < obs_sel.size(); i++) begin
      checks++;
      if (obs_sel[i] !== 4'(2 - i)) begin
        failures++;
        $display("FAIL b2b_select[%0d]: got %0d expected %0d", i, obs_sel[i], 2 - i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    int reqs;
    int xs;
    lat_l    = 3;
    model_en = 1'b1;
    reqs     = 0;
    drive_accept(4'd10);
    for (int c = 0; c < 200 && reqs < 5; c++) begin
      if (in_ready) reqs++;
      if (reqs < 5) @(negedge clk);
    end
    checks++;
    if (reqs !== 5 || sel !== 4'd6) begin
      failures++;
      $display("FAIL midop_iter5: got reqs=%0d sel=%0d expected reqs=5 sel=6", reqs, sel);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_wait: got ir=%b busy=%b expected ir=0 busy=1", in_ready, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, x_ready, acc_clear} !== 4'b0 || sel !== 4'(ORDER)) begin
      failures++;
      $display("FAIL midop_reset: got b/ir/x/clr=%b sel=%0d expected 0000 sel=%0d",
               {busy, in_ready, x_ready, acc_clear}, sel, ORDER);
    end
    reset = 1'b0;
    xs    = 0;
    reqs  = 0;
    repeat (40) begin
      @(negedge clk);
      if (x_ready) xs++;
      if (in_ready) reqs++;
    end
    checks++;
    if (xs !== 0 || reqs !== 0) begin
      failures++;
      $display("FAIL midop_quiet: got x=%0d reqs=%0d expected 0 0", xs, reqs);
    end
  endtask

  task automatic test_spurious;
    lat_l    = 2;
    model_en = 1'b1;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if ({busy, in_ready, x_ready} !== 3'b0 || sel !== 4'(ORDER)) begin
      failures++;
      $display("FAIL spur_idle: got b/ir/x=%b sel=%0d expected 000 sel=%0d",
               {busy, in_ready, x_ready}, sel, ORDER);
    end
    drive_accept(4'd1);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || sel !== 4'd1) begin
      failures++;
      $display("FAIL spur_issue: got ir=%b busy=%b sel=%0d expected ir=0 busy=1 sel=1",
               in_ready, busy, sel);
    end
    observe(2, 100);
    checks++;
    if (obs_lat !== 7 || obs_sel.size() !== 1 || obs_sel[0] !== 4'd0) begin
      failures++;
      $display("FAIL spur_complete: got lat=%0d reqs=%0d expected lat=7 reqs=1 sel=0",
               obs_lat, obs_sel.size());
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    int to_cyc;
    int to_cnt;
    int xs;
    logic busy_at;
    logic [SEL_W-1:0] sel_at;
    model_en = 1'b0;
    to_cyc   = -1;
    to_cnt   = 0;
    xs       = 0;
    busy_at  = 1'b1;
    sel_at   = '0;
    drive_accept(4'd0);
    for (int c = 1; c <= 100; c++) begin
      if (timeout) begin
        to_cnt++;
        if (to_cyc < 0) begin
          to_cyc  = c;
          busy_at = busy;
          sel_at  = sel;
        end
      end
      if (x_ready) xs++;
      if (c == 100) busy_at = (to_cyc < 0) ? busy : busy_at;
      @(negedge clk);
    end
`ifdef HORNER_FSM_WATCHDOG_EN
    checks++;
    if (to_cyc !== TO + 2 || to_cnt !== 1) begin
      failures++;
      $display("FAIL wd_timeout: got cycle=%0d pulses=%0d expected cycle=%0d pulses=1",
               to_cyc, to_cnt, TO + 2);
    end
    checks++;
    if (busy_at !== 1'b0 || sel_at !== 4'(ORDER) || xs !== 0) begin
      failures++;
      $display("FAIL wd_abort_state: got busy=%b sel=%0d x=%0d expected 0 %0d 0",
               busy_at, sel_at, xs, ORDER);
    end
`else
    checks++;
    if (to_cnt !== 0 || busy_at !== 1'b1 || xs !== 0) begin
      failures++;
      $display("FAIL nowd_hold: got timeouts=%0d busy=%b x=%0d expected 0 1 0",
               to_cnt, busy_at, xs);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    lat_l    = 1;
    model_en = 1'b1;
    drive_accept(4'd1);
    observe(1, 100);
    checks++;
    if (obs_lat !== 5 || obs_sel.size() !== 2) begin
      failures++;
      $display("FAIL wd_recover: got lat=%0d reqs=%0d expected lat=5 reqs=2",
               obs_lat, obs_sel.size());
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    adc   = 1'b0;
    cfg   = '0;
    test_reset();
    test_full_order();
    test_order_clamp();
    test_back_to_back();
    test_reset_midop();
    test_spurious();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
